wb_write_arbiter: RTL



---
 rtl/wisc_pkg.sv | 19 +
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/wb_write_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared writeback definitions: register-file geometry, special register indices and the queued-write entry.
package wisc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    localparam logic [3:0] REG_DS = 4'd14;
    localparam logic [3:0] REG_SP = 4'd15;

    typedef struct packed {
        logic [ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [15:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        reg_onehot = 16'h0001 << addr;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-push/one-pop FIFO of queued register writes, with an age-ordered view (index 0 = head).
// WB_FORWARD_EN additionally exports per-entry data for the forwarding lookup.
module wb_fifo
    import wisc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push0,
    input  wb_entry_t                       push0_entry,
    input  logic                            push1,
    input  wb_entry_t                       push1_entry,
    input  logic                            pop,
    output wb_entry_t                       head,
    output logic [CNT_W-1:0]                count,
    output logic [DEPTH-1:0]                age_valid,
`ifdef WB_FORWARD_EN
    output logic [DEPTH-1:0][DATA_W-1:0]    age_data,
`endif
    output logic [DEPTH-1:0][ADDR_W-1:0]    age_reg
);

    wb_entry_t          slots_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr1_idx_s;
    logic               pop_ok_s;

    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign wr1_idx_s = wr_ptr_r + PTR_W'(push0);

    // Entry storage: the load entry takes the first free slot, the ALU entry the slot behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '{reg_addr: {ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
        end else begin
            if (push0) begin
                slots_r[wr_ptr_r] <= push0_entry;
            end
            if (push1) begin
                slots_r[wr1_idx_s] <= push1_entry;
            end
        end
    end

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_ok_s);
            count_r  <= count_r + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_ok_s);
        end
    end

    // Age-ordered view of the live entries for the pending scoreboard and forwarding.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        idx_v = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx_v        = rd_ptr_r + PTR_W'(i);
            age_valid[i] = (CNT_W'(i) < count_r);
            age_reg[i]   = slots_r[idx_v].reg_addr;
`ifdef WB_FORWARD_EN
            age_data[i]  = slots_r[idx_v].data;
`endif
        end
    end

    assign head  = slots_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: queues load and ALU register writes in age order and issues one per cycle.
// WB_FORWARD_EN adds fwd_reg/fwd_hit/fwd_data, a lookup of the youngest queued value for a register.
module wb_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_wr_valid,
    input  logic [ADDR_W-1:0] mem_wr_reg,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ready,
    input  logic              alu_wr_valid,
    input  logic [ADDR_W-1:0] alu_wr_reg,
    input  logic [DATA_W-1:0] alu_wr_data,
    output logic              alu_wr_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Write_Reg,
    output logic [DATA_W-1:0] Write_Bus,
`ifdef WB_FORWARD_EN
    input  logic [ADDR_W-1:0] fwd_reg,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [15:0]       pending_mask
);
    import wisc_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]             count_s;
    logic [CNT_W-1:0]             free_s;
    logic                         push_mem_s;
    logic                         push_alu_s;
    logic                         pop_s;
    wb_entry_t                    mem_entry_s;
    wb_entry_t                    alu_entry_s;
    wb_entry_t                    head_s;
    logic [DEPTH-1:0]             age_valid_s;
    logic [DEPTH-1:0][ADDR_W-1:0] age_reg_s;
    logic [15:0]                  pending_s;
    logic                         reg_write_r;
    logic [ADDR_W-1:0]            write_reg_r;
    logic [DATA_W-1:0]            write_bus_r;
`ifdef WB_FORWARD_EN
    logic [DEPTH-1:0][DATA_W-1:0] age_data_s;
    logic                         fwd_hit_s;
    logic [DATA_W-1:0]            fwd_data_s;
`endif

    // Readiness looks only at occupancy, never at this cycle's pop; the ALU needs two slots
    // when a load competes so the older load is never starved.
    assign free_s       = CNT_W'(DEPTH) - count_s;
    assign mem_wr_ready = (free_s >= CNT_W'(1));
    assign alu_wr_ready = mem_wr_valid ? (free_s >= CNT_W'(2)) : (free_s >= CNT_W'(1));

    assign push_mem_s  = mem_wr_valid && mem_wr_ready;
    assign push_alu_s  = alu_wr_valid && alu_wr_ready;
    assign pop_s       = (count_s != {CNT_W{1'b0}});
    assign mem_entry_s = '{reg_addr: mem_wr_reg, data: mem_wr_data};
    assign alu_entry_s = '{reg_addr: alu_wr_reg, data: alu_wr_data};

    wb_fifo #(
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (push_mem_s),
        .push0_entry (mem_entry_s),
        .push1       (push_alu_s),
        .push1_entry (alu_entry_s),
        .pop         (pop_s),
        .head        (head_s),
        .count       (count_s),
        .age_valid   (age_valid_s),
`ifdef WB_FORWARD_EN
        .age_data    (age_data_s),
`endif
        .age_reg     (age_reg_s)
    );

    // Output stage: the head moves onto the register-file port whenever the FIFO holds an entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r <= 1'b0;
            write_reg_r <= {ADDR_W{1'b0}};
            write_bus_r <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            reg_write_r <= 1'b1;
            write_reg_r <= head_s.reg_addr;
            write_bus_r <= head_s.data;
        end else begin
            reg_write_r <= 1'b0;
        end
    end

    // Pending scoreboard: union of every live FIFO destination and the write being issued.
    always_comb begin
        pending_s = reg_write_r ? reg_onehot(write_reg_r) : 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            pending_s = pending_s | (age_valid_s[i] ? reg_onehot(age_reg_s[i]) : 16'h0000);
        end
    end

`ifdef WB_FORWARD_EN
    // Forward lookup scans oldest to youngest so the last match (youngest) supplies the data.
    always_comb begin
        logic match_v;
        match_v    = reg_write_r && (write_reg_r == fwd_reg);
        fwd_hit_s  = match_v;
        fwd_data_s = match_v ? write_bus_r : {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_v    = age_valid_s[i] && (age_reg_s[i] == fwd_reg);
            fwd_hit_s  = fwd_hit_s | match_v;
            fwd_data_s = match_v ? age_data_s[i] : fwd_data_s;
        end
    end

    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;
`else
    // Without forwarding there is no lookup network.
`endif

    assign RegWrite     = reg_write_r;
    assign Write_Reg    = write_reg_r;
    assign Write_Bus    = write_bus_r;
    assign pending_mask = pending_s;

endmodule
